// File: rtl/contador_botoes_pkg.sv
// Shared types and constants for the push-button counter and its display path.
package contador_botoes_pkg;

    // Count value as seen by display_7seg.
    typedef logic [3:0] contagem_t;

    // Raw and debounced buttons are active-low.
    localparam logic BTN_PRESSIONADO = 1'b0;

    // Next value going up, wrapping from max back to zero.
    function automatic contagem_t proximo_contagem(input contagem_t atual, input contagem_t maximo);
        return (atual == maximo) ? '0 : contagem_t'(atual + 4'd1);
    endfunction

    // Next value going down, wrapping from zero back to max.
    function automatic contagem_t anterior_contagem(input contagem_t atual, input contagem_t maximo);
        return (atual == '0) ? maximo : contagem_t'(atual - 4'd1);
    endfunction

endpackage

// File: rtl/contador_botoes_if.sv
// Button inputs and count outputs of the counter, grouped as one bundle.
interface contador_botoes_if;
    import contador_botoes_pkg::*;

    logic      btn_incrementa;
    logic      btn_decrementa;
    contagem_t contagem;
    logic      pulso_mudanca;

    // Board/bench side: drives the raw buttons, observes the count.
    modport master (
        output btn_incrementa,
        output btn_decrementa,
        input  contagem,
        input  pulso_mudanca
    );

    // Counter side.
    modport slave (
        input  btn_incrementa,
        input  btn_decrementa,
        output contagem,
        output pulso_mudanca
    );
endinterface

// File: rtl/contador_botoes_debounce_botao.sv
// One button: 2-FF synchroniser, stable-level debounce, and press pulse.
module debounce_botao
    import contador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_bruto,
    output logic btn_estavel,
    output logic pulso_pressao
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             estavel_q, estavel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulso_q, pulso_d;

    // Debounce: count cycles of disagreement, accept the new level on the last one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (sync2_q != estavel_q) begin
            if (cnt_q == CNT_FIM) begin
                estavel_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only the released -> pressed transition yields a step.
        pulso_d = (estavel_q != BTN_PRESSIONADO) && (estavel_d == BTN_PRESSIONADO);
    end

    // State registers; the synchroniser resets to "released" so nothing fires at boot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= ~BTN_PRESSIONADO;
            sync2_q   <= ~BTN_PRESSIONADO;
            estavel_q <= ~BTN_PRESSIONADO;
            cnt_q     <= '0;
            pulso_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so the two synchroniser stages shift rather than collapse.
            sync1_q   <= btn_bruto;
            sync2_q   <= sync1_q;
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
            pulso_q   <= pulso_d;
        end
    end

    assign btn_estavel   = estavel_q;
    assign pulso_pressao = pulso_q;

endmodule

// File: rtl/contador_botoes.sv
// Debounced up/down wrap counter driving the 7-segment count input.
module contador_botoes
    import contador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_COUNT       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    contador_botoes_if.slave   bus
);

    if (MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_max_count_invalido
        $error("MAX_COUNT must lie in 1..15");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_invalido
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    localparam contagem_t MAXIMO = contagem_t'(MAX_COUNT);

    logic      pressao_inc, pressao_dec;
    logic      estavel_inc_unused, estavel_dec_unused;
    contagem_t contagem_q, contagem_d;
    logic      pulso_q, pulso_d;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_bruto     (bus.btn_incrementa),
        .btn_estavel   (estavel_inc_unused),
        .pulso_pressao (pressao_inc)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_bruto     (bus.btn_decrementa),
        .btn_estavel   (estavel_dec_unused),
        .pulso_pressao (pressao_dec)
    );

    // Step the count on a lone press pulse; simultaneous presses cancel out.
    always_comb begin
        contagem_d = contagem_q;
        pulso_d    = 1'b0;
        if (pressao_inc && !pressao_dec) begin
            contagem_d = proximo_contagem(contagem_q, MAXIMO);
            pulso_d    = 1'b1;
        end else if (pressao_dec && !pressao_inc) begin
            contagem_d = anterior_contagem(contagem_q, MAXIMO);
            pulso_d    = 1'b1;
        end
    end

    // Count and strobe registers, so the strobe aligns with the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem_q <= '0;
            pulso_q    <= 1'b0;
        end else begin
            contagem_q <= contagem_d;
            pulso_q    <= pulso_d;
        end
    end

    assign bus.contagem      = contagem_q;
    assign bus.pulso_mudanca = pulso_q;

endmodule

// File: tb/tb_contador_botoes.sv
// Bench for contador_botoes with short debounce: table of presses plus corner sequences.
module tb_contador_botoes;
    import contador_botoes_pkg::*;

    localparam int DB  = 4;
    localparam int MAX = 5;

    typedef struct {
        string nome;
        logic  inc;
        logic  dec;
        int    hold;
        int    esperado;
    } vetor_t;

    logic clk;
    logic rst_n;
    contador_botoes_if bus();

    contador_botoes #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int sb_q[$];
    int exp_count   = 0;
    int prev_cont   = 0;

    task automatic check(input string nome, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, actual, required, $time);
        end
    endtask

    // Reference model of one step, pushed to the scoreboard when a change is due.
    task automatic modelo(input logic inc, input logic dec);
        if (inc && !dec) begin
            exp_count = (exp_count == MAX) ? 0 : exp_count + 1;
            sb_q.push_back(exp_count);
        end else if (dec && !inc) begin
            exp_count = (exp_count == 0) ? MAX : exp_count - 1;
            sb_q.push_back(exp_count);
        end
    endtask

    // Monitor: every strobe pops one expected value; any silent change is an error.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cont = 0;
        end else begin
            if (bus.pulso_mudanca) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL strobe_unexpected: got strobe with contagem=%0d, expected no strobe (t=%0t)",
                             bus.contagem, $time);
                end else begin
                    check("strobe_value", int'(bus.contagem), sb_q.pop_front());
                end
            end else if (int'(bus.contagem) != prev_cont) begin
                vectors++;
                miscompares++;
                $display("FAIL silent_change: got contagem=%0d, expected %0d without strobe (t=%0t)",
                         bus.contagem, prev_cont, $time);
            end
            prev_cont = int'(bus.contagem);
        end
    end

    task automatic aperta(input logic inc, input logic dec, input int hold);
        @(posedge clk); #1;
        bus.btn_incrementa = ~inc;
        bus.btn_decrementa = ~dec;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_incrementa = 1'b1;
        bus.btn_decrementa = 1'b1;
        repeat (15) @(posedge clk);
        #1;
    endtask

    vetor_t tbl[10];

    initial begin
        int  lat;
        bit  achou;

        tbl[0] = '{"inc_1_2",    1'b1, 1'b0, 20, 2};
        tbl[1] = '{"inc_2_3",    1'b1, 1'b0, 20, 3};
        tbl[2] = '{"inc_3_4",    1'b1, 1'b0, 20, 4};
        tbl[3] = '{"inc_4_5",    1'b1, 1'b0, 20, 5};
        tbl[4] = '{"inc_wrap_0", 1'b1, 1'b0, 20, 0};
        tbl[5] = '{"dec_wrap_5", 1'b0, 1'b1, 20, 5};
        tbl[6] = '{"dec_5_4",    1'b0, 1'b1, 20, 4};
        tbl[7] = '{"dec_4_3",    1'b0, 1'b1, 20, 3};
        tbl[8] = '{"both_hold3", 1'b1, 1'b1, 20, 3};
        tbl[9] = '{"inc_3_4b",   1'b1, 1'b0,  6, 4};

        // Reset held for three cycles with buttons released.
        rst_n              = 1'b0;
        bus.btn_incrementa = 1'b1;
        bus.btn_decrementa = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_contagem", int'(bus.contagem), 0);
            check("reset_pulso", int'(bus.pulso_mudanca), 0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_contagem", int'(bus.contagem), 0);
            check("post_reset_pulso", int'(bus.pulso_mudanca), 0);
        end

        // Clean press: measure raw edge to strobe latency.
        modelo(1'b1, 1'b0);
        @(posedge clk); #1;
        bus.btn_incrementa = 1'b0;
        lat   = 0;
        achou = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.pulso_mudanca && !achou) begin
                lat   = n;
                achou = 1'b1;
            end
        end
        check("press_seen", int'(achou), 1);
        check("press_latency_7_8", int'(lat >= 7 && lat <= 8), 1);
        @(posedge clk); #1;
        bus.btn_incrementa = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("clean_press_contagem", int'(bus.contagem), 1);

        // Table of presses: wrap up, wrap down, simultaneous press.
        for (int i = 0; i < 10; i++) begin
            modelo(tbl[i].inc, tbl[i].dec);
            aperta(tbl[i].inc, tbl[i].dec, tbl[i].hold);
            check(tbl[i].nome, int'(bus.contagem), tbl[i].esperado);
            check({tbl[i].nome, "_sb_empty"}, sb_q.size(), 0);
        end

        // Bouncing decrement: 2-cycle runs never reach the debounce threshold.
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            bus.btn_decrementa = ~bus.btn_decrementa;
            repeat (2) @(posedge clk);
            #1;
        end
        bus.btn_decrementa = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("bounce_contagem", int'(bus.contagem), 4);

        // Reset mid-debounce with increment held, then re-debounce after release.
        @(posedge clk); #1;
        bus.btn_incrementa = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_contagem", int'(bus.contagem), 0);
        check("async_reset_pulso", int'(bus.pulso_mudanca), 0);
        exp_count = 0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        modelo(1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        check("held_after_reset_contagem", int'(bus.contagem), 1);
        check("held_after_reset_sb_empty", sb_q.size(), 0);
        bus.btn_incrementa = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("release_after_reset_contagem", int'(bus.contagem), 1);

        check("final_sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
